i2c_slave_rx: RTL and testbench

- Write-only I2C slave receiver that sits directly upstream of the slave command-processing FSM.
- Oversamples the SCL/SDA pads on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs each byte, and delivers received bytes with a single-cycle `done` strobe and a byte index.
- Byte index counts modulo 3 (opcode, operand1, operand2), so the downstream FSM sees clean, synchronous byte boundaries.

---
 rtl/i2c_slave_rx_pkg.sv | 10 +
 rtl/i2c_sync_edge.sv | 27 ++
 rtl/i2c_slave_rx.sv | 98 +++++++++
 tb/tb_i2c_slave_rx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/i2c_slave_rx_pkg.sv
// i2c_slave_rx_pkg: shared states, bus constants and command opcodes for the I2C write slave
package i2c_slave_rx_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;
  localparam logic I2C_RW_WRITE = 1'b0;
  localparam int BYTES_PER_CMD_DEF = 3;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_WRITE_REG = 8'h02;
  localparam logic [7:0] OP_SET_MODE = 8'h05;
  localparam logic [7:0] OP_RESET = 8'h07;
endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: pad synchronizer with registered level and aligned rise/fall pulses
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES-1:0] sync;
  // chain resets to the idle bus level so leaving reset never fakes an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '1;
      level <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], din};
      level <= sync[SYNC_STAGES-1];
      rise <= sync[SYNC_STAGES-1] & ~level;
      fall <= ~sync[SYNC_STAGES-1] & level;
    end
  end
endmodule

// File: rtl/i2c_slave_rx.sv
// i2c_slave_rx: write-only I2C slave that ACKs its address and streams bytes with a modulo index
module i2c_slave_rx
  import i2c_slave_rx_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int SYNC_STAGES = 2,
  parameter int BYTES_PER_CMD = BYTES_PER_CMD_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] data_out,
  output logic       done,
  output logic [1:0] byte_idx,
  output logic       busy,
  output logic       addr_err
);
  logic scl_l, sclr, sclf, sda_l, sda_r, sda_f, start, stop;
  state_t state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic [1:0] cnt;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk(clk), .rst(rst), .din(scl_in), .level(scl_l), .rise(sclr), .fall(sclf)
  );
  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk(clk), .rst(rst), .din(sda_in), .level(sda_l), .rise(sda_r), .fall(sda_f)
  );

  assign start = sda_f & scl_l;
  assign stop = sda_r & scl_l;

  // bus protocol FSM; START/STOP outrank any coincident SCL edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      shreg <= '0;
      bit_cnt <= '0;
      cnt <= '0;
      sda_oe <= 1'b0;
      data_out <= '0;
      done <= 1'b0;
      byte_idx <= '0;
      busy <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      done <= 1'b0;
      addr_err <= 1'b0;
      if (stop) begin
        state <= IDLE;
        sda_oe <= 1'b0;
        busy <= 1'b0;
      end else if (start) begin
        state <= ADDR;
        sda_oe <= 1'b0;
        bit_cnt <= '0;
        cnt <= '0;
        byte_idx <= '0;
      end else begin
        case (state)
          ADDR, DATA: begin
            if (sclr) begin
              shreg <= {shreg[6:0], sda_l};
              bit_cnt <= bit_cnt + 4'd1;
            end else if (sclf && bit_cnt == 4'd8) begin
              bit_cnt <= '0;
              if (state == DATA) begin
                data_out <= shreg;
                done <= 1'b1;
                byte_idx <= cnt;
                cnt <= (cnt == 2'(BYTES_PER_CMD - 1)) ? 2'd0 : cnt + 2'd1;
                sda_oe <= 1'b1;
                state <= DATA_ACK;
              end else if (shreg[7:1] == SLAVE_ADDR && shreg[0] == I2C_RW_WRITE) begin
                sda_oe <= 1'b1;
                busy <= 1'b1;
                state <= ADDR_ACK;
              end else begin
                addr_err <= 1'b1;
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (sclf) begin
              sda_oe <= 1'b0;
              state <= DATA;
            end
          end
          default: sda_oe <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb_i2c_slave_rx: bit-banged I2C master with a done/addr_err scoreboard monitor
module tb_i2c_slave_rx;
  localparam int Q = 8;
  logic clk = 1'b0;
  logic rst, scl, sda_m, sda;
  logic sda_oe, done, busy, addr_err;
  logic [7:0] data_out;
  logic [1:0] byte_idx;
  logic [9:0] sb[$];
  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp = 0;

  assign sda = sda_m & ~sda_oe;

  i2c_slave_rx dut (
    .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda), .sda_oe(sda_oe),
    .data_out(data_out), .done(done), .byte_idx(byte_idx), .busy(busy), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, output logic s);
    sda_m = b;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    s = sda;
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic start_c;
    sda_m = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    sda_m = 1'b0;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
  endtask

  task automatic stop_c;
    sda_m = 1'b0;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q);
    sda_m = 1'b1;
    wait_clks(2 * Q);
  endtask

  task automatic xfer(input string name, input logic [7:0] b, input logic exp_ack);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    chk(name, s, exp_ack);
  endtask

  task automatic push(input logic [1:0] idx, input logic [7:0] d);
    sb.push_back({idx, d});
  endtask

  // monitor: every done pops the scoreboard, every addr_err pulse is counted
  initial begin
    logic [9:0] e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=%0h required=none", data_out);
        end else begin
          e = sb.pop_front();
          chk("done_data", data_out, e[7:0]);
          chk("done_idx", byte_idx, e[9:8]);
        end
      end
      if (addr_err === 1'b1) err_seen++;
    end
  end

  initial begin
    #500us;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic s;
    rst = 1'b1;
    scl = 1'b1;
    sda_m = 1'b1;
    wait_clks(3);
    chk("reset_outputs", {sda_oe, done, busy, addr_err, byte_idx, data_out}, 0);
    rst = 1'b0;
    wait_clks(4);
    // four-byte write: ACKs, idx 0/1/2 then wrap to 0
    start_c();
    xfer("t1_addr_ack", 8'h84, 1'b0);
    chk("t1_busy", busy, 1);
    push(0, 8'h02); xfer("t1_b0_ack", 8'h02, 1'b0);
    push(1, 8'h05); xfer("t1_b1_ack", 8'h05, 1'b0);
    push(2, 8'h07); xfer("t1_b2_ack", 8'h07, 1'b0);
    push(0, 8'h09); xfer("t1_b3_ack", 8'h09, 1'b0);
    chk("t1_busy_mid", busy, 1);
    stop_c();
    chk("t1_busy_after", busy, 0);
    chk("t1_hold", {byte_idx, data_out}, {2'd0, 8'h09});
    // wrong address: NACK, one addr_err, following byte ignored
    start_c();
    err_exp++;
    xfer("t2_addr_nack", 8'h86, 1'b1);
    xfer("t2_byte_nack", 8'h11, 1'b1);
    chk("t2_err", err_seen, err_exp);
    chk("t2_busy", busy, 0);
    stop_c();
    // read request NACKed, then a normal write
    start_c();
    err_exp++;
    xfer("t3_read_nack", 8'h85, 1'b1);
    chk("t3_err", err_seen, err_exp);
    stop_c();
    start_c();
    xfer("t3_addr_ack", 8'h84, 1'b0);
    push(0, 8'hAB); xfer("t3_b0_ack", 8'hAB, 1'b0);
    stop_c();
    // STOP mid-byte discards the partial byte and returns to IDLE
    start_c();
    xfer("t4_addr_ack", 8'h84, 1'b0);
    push(0, 8'h11); xfer("t4_b0_ack", 8'h11, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, s);
    stop_c();
    chk("t4_busy", busy, 0);
    xfer("t4_idle_nack", 8'h84, 1'b1);
    chk("t4_err", err_seen, err_exp);
    chk("t4_hold", data_out, 8'h11);
    sda_m = 1'b1;
    scl = 1'b1;
    wait_clks(Q);
    // repeated START resets the byte index
    start_c();
    xfer("t5_addr_ack", 8'h84, 1'b0);
    push(0, 8'hAA); xfer("t5_b0_ack", 8'hAA, 1'b0);
    start_c();
    xfer("t5_addr2_ack", 8'h84, 1'b0);
    push(0, 8'h55); xfer("t5_b1_ack", 8'h55, 1'b0);
    stop_c();
    // reset while the address ACK is driven
    start_c();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i), s);
    sda_m = 1'b1;
    wait_clks(Q);
    scl = 1'b1;
    wait_clks(Q / 2);
    chk("t6_ack_driven", sda_oe, 1);
    rst = 1'b1;
    wait_clks(1);
    chk("t6_rst_release", {sda_oe, busy}, 0);
    rst = 1'b0;
    wait_clks(Q);
    scl = 1'b0;
    wait_clks(Q);
    stop_c();
    start_c();
    xfer("t6_addr_ack", 8'h84, 1'b0);
    push(0, 8'h33); xfer("t6_b0_ack", 8'h33, 1'b0);
    push(1, 8'h44); xfer("t6_b1_ack", 8'h44, 1'b0);
    stop_c();
    wait_clks(10);
    chk("sb_empty", sb.size(), 0);
    chk("final_err", err_seen, err_exp);
    chk("final_hold", {byte_idx, data_out}, {2'd1, 8'h44});
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
